// File: rtl/sequenciador_multiciclo_pkg.sv
// Shared definitions for the multi-cycle control sequencer: state encoding,
// opcode constants, PC source codes and the decoded instruction class.
package sequenciador_multiciclo_pkg;

    typedef enum logic [2:0] {
        BUSCA      = 3'd0,
        DECODIFICA = 3'd1,
        EXECUTA    = 3'd2,
        MEMORIA    = 3'd3,
        ESCRITA    = 3'd4,
        PARADO     = 3'd5
    } estado_t;

    localparam logic [3:0] OP_LW   = 4'b1100;
    localparam logic [3:0] OP_SW   = 4'b1101;
    localparam logic [3:0] OP_JUMP = 4'b1110;
    localparam logic [3:0] OP_HALT = 4'b1111;

    // Two-bit opcode prefixes for the classes that ignore opcode[1:0]
    localparam logic [1:0] PFX_BEQ    = 2'b00;
    localparam logic [1:0] PFX_ILEGAL = 2'b01;
    localparam logic [1:0] PFX_ALU    = 2'b10;

    localparam logic [1:0] PC_MAIS_UM = 2'b00;
    localparam logic [1:0] PC_DESVIO  = 2'b01;
    localparam logic [1:0] PC_SALTO   = 2'b10;

    localparam logic [1:0] REG_SALTO_BEQ = 2'b10;

    typedef struct packed {
        logic lw;
        logic sw;
        logic beq;
        logic alu;
        logic jump;
        logic halt;
        logic ilegal;
    } classe_t;

endpackage

// File: rtl/sequenciador_multiciclo_if.sv
// Control/status bundle between the sequencer (master) and the datapath (slave).
interface sequenciador_multiciclo_if;
    logic [7:0] instrucao;
    logic       ula_zero;
    logic       mem_pronta;
    logic       pc_escreve;
    logic [1:0] pc_origem;
    logic       ir_escreve;
    logic       le_mem;
    logic       escreve_mem;
    logic       reg_escreve;
    logic       mem_reg;
    logic       origem;
    logic       op_alu;
    logic [1:0] decide_reg_salto;
    logic       halt;
    logic       erro_mem;
    logic       ilegal;
    logic [7:0] instr_concluidas;
    logic [2:0] estado;

    modport master (
        input  instrucao, ula_zero, mem_pronta,
        output pc_escreve, pc_origem, ir_escreve, le_mem, escreve_mem,
               reg_escreve, mem_reg, origem, op_alu, decide_reg_salto,
               halt, erro_mem, ilegal, instr_concluidas, estado
    );

    modport slave (
        output instrucao, ula_zero, mem_pronta,
        input  pc_escreve, pc_origem, ir_escreve, le_mem, escreve_mem,
               reg_escreve, mem_reg, origem, op_alu, decide_reg_salto,
               halt, erro_mem, ilegal, instr_concluidas, estado
    );
endinterface

// File: rtl/sequenciador_multiciclo_decodificador_classe.sv
// Combinational opcode to one-hot instruction class decoder.
module decodificador_classe
    import sequenciador_multiciclo_pkg::*;
(
    input  logic [3:0] opcode,
    output classe_t    classe
);

    always_comb begin
        classe        = '0;
        classe.lw     = (opcode == OP_LW);
        classe.sw     = (opcode == OP_SW);
        classe.jump   = (opcode == OP_JUMP);
        classe.halt   = (opcode == OP_HALT);
        classe.beq    = (opcode[3:2] == PFX_BEQ);
        classe.alu    = (opcode[3:2] == PFX_ALU);
        classe.ilegal = (opcode[3:2] == PFX_ILEGAL);
    end

endmodule

// File: rtl/sequenciador_multiciclo.sv
// Multi-cycle fetch/decode/execute/memory/writeback sequencer for the 8-bit core.
// Strobes decode from the state and latched opcode; the BEQ PC write also follows ula_zero.
module sequenciador_multiciclo
    import sequenciador_multiciclo_pkg::*;
#(
    parameter int ESPERA_MAX = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    sequenciador_multiciclo_if.master bus
);

    localparam logic [3:0] ESPERA_LIM = 4'(ESPERA_MAX);

    estado_t    state_reg;
    logic [3:0] opcode_reg;
    logic [3:0] espera_reg;
    logic [7:0] contador_reg;
    logic       erro_reg;
    classe_t    classe;

    // Operand nibble goes straight to the datapath; only the opcode matters here
    logic unused_operando;
    assign unused_operando = ^bus.instrucao[3:0];

    decodificador_classe u_decodificador_classe (
        .opcode (opcode_reg),
        .classe (classe)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg    <= BUSCA;
            opcode_reg   <= '0;
            espera_reg   <= '0;
            contador_reg <= '0;
            erro_reg     <= 1'b0;
        end else begin
            case (state_reg)
                BUSCA: begin
                    opcode_reg <= bus.instrucao[7:4];
                    state_reg  <= DECODIFICA;
                end
                DECODIFICA: begin
                    state_reg <= classe.halt ? PARADO : EXECUTA;
                end
                EXECUTA: begin
                    if (classe.alu) begin
                        state_reg <= ESCRITA;
                    end else if (classe.lw || classe.sw) begin
                        state_reg  <= MEMORIA;
                        espera_reg <= '0;
                    end else begin
                        state_reg    <= BUSCA;
                        contador_reg <= contador_reg + 8'd1;
                    end
                end
                MEMORIA: begin
                    // Ready is checked first so it wins over a timeout in the same cycle
                    if (bus.mem_pronta) begin
                        if (classe.lw) begin
                            state_reg <= ESCRITA;
                        end else begin
                            state_reg    <= BUSCA;
                            contador_reg <= contador_reg + 8'd1;
                        end
                    end else begin
                        espera_reg <= espera_reg + 4'd1;
                        if ((espera_reg + 4'd1) == ESPERA_LIM) begin
                            state_reg <= PARADO;
                            erro_reg  <= 1'b1;
                        end
                    end
                end
                ESCRITA: begin
                    state_reg    <= BUSCA;
                    contador_reg <= contador_reg + 8'd1;
                end
                PARADO: begin
                    state_reg <= PARADO;
                end
                default: begin
                    state_reg <= BUSCA;
                end
            endcase
        end
    end

    always_comb begin
        bus.pc_escreve       = 1'b0;
        bus.pc_origem        = PC_MAIS_UM;
        bus.ir_escreve       = 1'b0;
        bus.le_mem           = 1'b0;
        bus.escreve_mem      = 1'b0;
        bus.reg_escreve      = 1'b0;
        bus.mem_reg          = 1'b0;
        bus.origem           = 1'b0;
        bus.op_alu           = 1'b0;
        bus.decide_reg_salto = 2'b00;
        bus.halt             = 1'b0;
        bus.ilegal           = 1'b0;
        if (!reset) begin
            case (state_reg)
                BUSCA: begin
                    bus.ir_escreve = 1'b1;
                    bus.pc_escreve = 1'b1;
                    bus.pc_origem  = PC_MAIS_UM;
                end
                EXECUTA: begin
                    if (classe.alu || classe.lw || classe.sw) begin
                        bus.origem = 1'b1;
                        bus.op_alu = classe.alu;
                    end else if (classe.beq) begin
                        bus.op_alu           = 1'b1;
                        bus.decide_reg_salto = REG_SALTO_BEQ;
                        if (bus.ula_zero) begin
                            bus.pc_escreve = 1'b1;
                            bus.pc_origem  = PC_DESVIO;
                        end
                    end else if (classe.jump) begin
                        bus.pc_escreve = 1'b1;
                        bus.pc_origem  = PC_SALTO;
                    end else if (classe.ilegal) begin
                        bus.ilegal = 1'b1;
                    end
                end
                MEMORIA: begin
                    bus.le_mem      = classe.lw;
                    bus.escreve_mem = classe.sw;
                end
                ESCRITA: begin
                    bus.reg_escreve = 1'b1;
                    bus.mem_reg     = classe.lw;
                end
                PARADO: begin
                    bus.halt = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.erro_mem         = erro_reg;
    assign bus.instr_concluidas = contador_reg;
    assign bus.estado           = state_reg;

endmodule

// File: tb/tb_sequenciador_multiciclo.sv
// Directed bench for the multi-cycle sequencer: a per-instruction schedule model
// checks every cycle, and literal expectations pin latencies and key strobes.
module tb_sequenciador_multiciclo;

    localparam int ESPERA_MAX = 4;

    typedef struct packed {
        logic [2:0] estado;
        logic       pc_escreve;
        logic [1:0] pc_origem;
        logic       ir_escreve;
        logic       le_mem;
        logic       escreve_mem;
        logic       reg_escreve;
        logic       mem_reg;
        logic       origem;
        logic       op_alu;
        logic [1:0] decide;
        logic       halt;
        logic       erro;
        logic       ilegal;
        logic [7:0] cnt;
    } obs_t;

    logic clock = 1'b0;
    logic reset = 1'b1;

    sequenciador_multiciclo_if bus ();

    sequenciador_multiciclo #(.ESPERA_MAX(ESPERA_MAX)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int   n_checks = 0;
    int   n_fails  = 0;
    int   m_cnt    = 0;
    bit   m_erro   = 0;
    obs_t hist[$];

    function automatic obs_t sample();
        obs_t o;
        o.estado      = bus.estado;
        o.pc_escreve  = bus.pc_escreve;
        o.pc_origem   = bus.pc_origem;
        o.ir_escreve  = bus.ir_escreve;
        o.le_mem      = bus.le_mem;
        o.escreve_mem = bus.escreve_mem;
        o.reg_escreve = bus.reg_escreve;
        o.mem_reg     = bus.mem_reg;
        o.origem      = bus.origem;
        o.op_alu      = bus.op_alu;
        o.decide      = bus.decide_reg_salto;
        o.halt        = bus.halt;
        o.erro        = bus.erro_mem;
        o.ilegal      = bus.ilegal;
        o.cnt         = bus.instr_concluidas;
        return o;
    endfunction

    function automatic obs_t idle(input logic [2:0] st);
        obs_t o = '0;
        o.estado = st;
        o.cnt    = 8'(m_cnt);
        o.erro   = m_erro;
        return o;
    endfunction

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // One cycle: drive mem_pronta, compare at the falling edge, advance past the next rising edge
    task automatic step(input string name, input obs_t e, input bit mp);
        obs_t got;
        bus.mem_pronta = mp;
        @(negedge clock);
        got = sample();
        hist.push_back(got);
        n_checks++;
        if (got !== e) begin
            n_fails++;
            $display("FAIL cycle_%s: got %h expected %h", name, got, e);
        end
        @(posedge clock);
        #1;
    endtask

    // w = number of not-ready MEMORIA cycles before ready; negative = never ready
    task automatic run_instr(input logic [7:0] ins, input bit z, input int w);
        obs_t       e;
        logic [3:0] op;
        op = ins[7:4];
        hist.delete();
        bus.instrucao = ins;
        bus.ula_zero  = z;
        e = idle(3'd0); e.ir_escreve = 1; e.pc_escreve = 1;
        step("busca", e, 0);
        e = idle(3'd1);
        step("decodifica", e, 0);
        if (op == 4'hF) begin
            repeat (3) begin
                e = idle(3'd5); e.halt = 1;
                step("parado", e, 0);
            end
            return;
        end
        e = idle(3'd2);
        if (op[3:2] == 2'b00) begin
            e.op_alu = 1; e.decide = 2'b10;
            if (z) begin e.pc_escreve = 1; e.pc_origem = 2'b01; end
            step("beq", e, 0);
        end else if (op[3:2] == 2'b01) begin
            e.ilegal = 1;
            step("ilegal", e, 0);
        end else if (op[3:2] == 2'b10) begin
            e.origem = 1; e.op_alu = 1;
            step("alu_exec", e, 0);
            e = idle(3'd4); e.reg_escreve = 1;
            step("alu_escrita", e, 0);
        end else if (op == 4'hE) begin
            e.pc_escreve = 1; e.pc_origem = 2'b10;
            step("jump", e, 0);
        end else begin
            e.origem = 1;
            step("mem_exec", e, 0);
            for (int i = 0; ; i++) begin
                bit rdy;
                rdy = (i == w);
                e = idle(3'd3);
                if (op == 4'hC) e.le_mem = 1; else e.escreve_mem = 1;
                step("memoria", e, rdy);
                if (rdy) break;
                if (i + 1 == ESPERA_MAX) begin
                    m_erro = 1;
                    repeat (3) begin
                        e = idle(3'd5); e.halt = 1;
                        step("timeout", e, 0);
                    end
                    return;
                end
            end
            if (op == 4'hC) begin
                e = idle(3'd4); e.reg_escreve = 1; e.mem_reg = 1;
                step("lw_escrita", e, 0);
            end
        end
        m_cnt = (m_cnt + 1) % 256;
    endtask

    task automatic do_reset();
        reset = 1;
        bus.mem_pronta = 0;
        @(posedge clock);
        #1;
        @(negedge clock);
        check("reset_estado", 16'(bus.estado), 16'd0);
        check("reset_ir_forced_low", 16'(bus.ir_escreve), 16'd0);
        check("reset_cnt", 16'(bus.instr_concluidas), 16'd0);
        check("reset_erro", 16'(bus.erro_mem), 16'd0);
        check("reset_halt", 16'(bus.halt), 16'd0);
        @(posedge clock);
        #1;
        reset  = 0;
        m_cnt  = 0;
        m_erro = 0;
    endtask

    function automatic int count_le();
        int n = 0;
        foreach (hist[i]) n += int'(hist[i].le_mem);
        return n;
    endfunction

    function automatic int count_esc();
        int n = 0;
        foreach (hist[i]) n += int'(hist[i].escreve_mem);
        return n;
    endfunction

    function automatic int count_ilegal();
        int n = 0;
        foreach (hist[i]) n += int'(hist[i].ilegal);
        return n;
    endfunction

    initial begin
        obs_t e;
        bus.instrucao  = 8'h00;
        bus.ula_zero   = 0;
        bus.mem_pronta = 0;
        do_reset();

        run_instr(8'b10011001, 0, 0);
        $display("ALU   10011001 cycles=%0d cnt=%0d", hist.size(), bus.instr_concluidas);
        check("alu_latency", 16'(hist.size()), 16'd4);
        check("alu_ir_c1", 16'(hist[0].ir_escreve), 16'd1);
        check("alu_origem_opalu_c3", {14'd0, hist[2].origem, hist[2].op_alu}, 16'h3);
        check("alu_escrita_c4", {14'd0, hist[3].reg_escreve, hist[3].mem_reg}, 16'h2);
        check("alu_cnt", 16'(bus.instr_concluidas), 16'd1);

        run_instr(8'b11001000, 0, 1);
        $display("LW    11001000 cycles=%0d cnt=%0d", hist.size(), bus.instr_concluidas);
        check("lw_latency", 16'(hist.size()), 16'd6);
        check("lw_le_cycles", 16'(count_le()), 16'd2);
        check("lw_escrita", {14'd0, hist[5].reg_escreve, hist[5].mem_reg}, 16'h3);

        run_instr(8'b00101000, 1, 0);
        $display("BEQ   z=1 cycles=%0d", hist.size());
        check("beq_taken_latency", 16'(hist.size()), 16'd3);
        check("beq_taken_pc", {13'd0, hist[2].pc_escreve, hist[2].pc_origem}, 16'h5);
        run_instr(8'b00101000, 0, 0);
        $display("BEQ   z=0 cycles=%0d", hist.size());
        check("beq_not_taken_pc", 16'(hist[2].pc_escreve), 16'd0);

        run_instr(8'b11010001, 0, 0);
        $display("SW    w=0 cycles=%0d", hist.size());
        check("sw_latency", 16'(hist.size()), 16'd4);
        run_instr(8'b11010001, 0, ESPERA_MAX - 1);
        $display("SW    w=%0d ready at limit cycles=%0d erro=%0d", ESPERA_MAX - 1, hist.size(), bus.erro_mem);
        check("sw_ready_wins_latency", 16'(hist.size()), 16'd7);
        check("sw_ready_wins_no_erro", 16'(bus.erro_mem), 16'd0);

        run_instr(8'hE3, 0, 0);
        $display("JUMP  cycles=%0d", hist.size());
        check("jump_latency", 16'(hist.size()), 16'd3);

        run_instr(8'b01010000, 0, 0);
        $display("ILEG  01010000 cycles=%0d", hist.size());
        check("ilegal_pulses", 16'(count_ilegal()), 16'd1);
        check("ilegal_back_busca", 16'(bus.estado), 16'd0);
        check("ilegal_cnt", 16'(bus.instr_concluidas), 16'd8);

        run_instr(8'b11111000, 0, 0);
        $display("HALT  11111000 halt=%0d", bus.halt);
        check("halt_c3", 16'(hist[2].halt), 16'd1);
        check("halt_cnt_kept", 16'(bus.instr_concluidas), 16'd8);

        do_reset();
        run_instr(8'b11010001, 0, -1);
        $display("SW    timeout esc_cycles=%0d halt=%0d erro=%0d", count_esc(), bus.halt, bus.erro_mem);
        check("timeout_esc_cycles", 16'(count_esc()), 16'd4);
        check("timeout_halt_erro", {14'd0, bus.halt, bus.erro_mem}, 16'h3);
        check("timeout_cnt", 16'(bus.instr_concluidas), 16'd0);

        do_reset();
        run_instr(8'hE0, 0, 0);
        run_instr(8'hE0, 0, 0);
        bus.instrucao = 8'b11001000;
        e = idle(3'd0); e.ir_escreve = 1; e.pc_escreve = 1;
        step("abort_busca", e, 0);
        e = idle(3'd1);
        step("abort_decodifica", e, 0);
        e = idle(3'd2); e.origem = 1;
        step("abort_exec", e, 0);
        e = idle(3'd3); e.le_mem = 1;
        step("abort_mem", e, 0);
        reset = 1;
        @(negedge clock);
        $display("RESET in MEMORIA le_mem=%0d estado=%0d", bus.le_mem, bus.estado);
        check("abort_le_drops", 16'(bus.le_mem), 16'd0);
        check("abort_estado_still_mem", 16'(bus.estado), 16'd3);
        @(posedge clock);
        #1;
        check("abort_estado_busca", 16'(bus.estado), 16'd0);
        check("abort_cnt_cleared", 16'(bus.instr_concluidas), 16'd0);
        reset  = 0;
        m_cnt  = 0;
        m_erro = 0;

        for (int k = 0; k < 256; k++) begin
            run_instr(8'hE0, 0, 0);
            if (k == 254) check("jump_cnt_255", 16'(bus.instr_concluidas), 16'd255);
        end
        $display("JUMP  x256 cnt=%0d", bus.instr_concluidas);
        check("jump_cnt_wrap", 16'(bus.instr_concluidas), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/sequenciador_multiciclo.md
# sequenciador_multiciclo

Multi-cycle control sequencer for the 8-bit processor datapath. It replaces per-clock opcode decoding with a fetch/decode/execute/memory/writeback state machine. It drives PC update, instruction-register load, ALU and mux selects, data-memory strobes and register-bank write. It also waits on a data-memory ready handshake with timeout, and halts the core on the halt opcode or a memory timeout.

## Interface
- `ESPERA_MAX`, default 4: maximum cycles spent in MEMORIA without `mem_pronta` before a timeout fault (range 1–15).

- `clock`  in  1  system clock; all state updates on the rising edge
- `reset`  in  1  reset, synchronous, active-high
- `instrucao`  in  8  instruction-memory output at the current PC; bits [7:4] are the opcode
- `ula_zero`  in  1  ALU result == 0, valid in EXECUTA
- `mem_pronta`  in  1  data memory has completed the current read/write
- `pc_escreve`  out  1  PC load enable
- `pc_origem`  out  2  PC source select: 00 = PC+1, 01 = branch target register, 10 = jump target
- `ir_escreve`  out  1  instruction-register load enable
- `le_mem`, `escreve_mem`  out  1 each  data-memory read and write strobes
- `reg_escreve`  out  1  register-bank write enable
- `mem_reg`  out  1  writeback select: 1 = memory data, 0 = ALU result
- `origem`  out  1  ALU B operand: 1 = zero-extended immediate from `instrucao[3:0]`, 0 = register
- `op_alu`  out  1  0 = add, 1 = subtract
- `decide_reg_salto`  out  2  branch-target register select (10 = $beq)
- `halt`  out  1  core stopped
- `erro_mem`  out  1  sticky; set when halt was caused by a memory timeout
- `ilegal`  out  1  one-cycle pulse on an undefined opcode
- `instr_concluidas`  out  8  retired-instruction counter, wraps 255→0
- `estado`  out  3  current state, for debug

## Operation
- Opcode classes:
  - 1100 LW
  - 1101 SW
  - 00zz BEQ
  - 10zz ALU-immediate (subtract)
  - 1110 JUMP
  - 1111 HALT
  - 01zz illegal
- The opcode is latched into an internal register in BUSCA and is stable for the rest of the instruction.
- States and per-state outputs:
  - BUSCA: `ir_escreve` = 1, `pc_escreve` = 1, `pc_origem` = 00. Next state is DECODIFICA.
  - DECODIFICA: no strobes. HALT → PARADO; all other opcodes → EXECUTA.
  - EXECUTA, ALU: `origem` = 1, `op_alu` = 1. Next state is ESCRITA.
  - EXECUTA, LW/SW: `origem` = 1, `op_alu` = 0. Next state is MEMORIA.
  - EXECUTA, BEQ: `op_alu` = 1, `decide_reg_salto` = 10. If `ula_zero` = 1: `pc_escreve` = 1 and `pc_origem` = 01; this output is Mealy, combinational on `ula_zero`. Next state is BUSCA.
  - EXECUTA, JUMP: `pc_escreve` = 1, `pc_origem` = 10. Next state is BUSCA.
  - EXECUTA, illegal: `ilegal` = 1, no other strobe. Next state is BUSCA.
  - MEMORIA: `le_mem` (LW) or `escreve_mem` (SW) is held high every cycle.
    - `mem_pronta` = 1: LW → ESCRITA; SW → BUSCA.
    - `mem_pronta` = 0: the wait counter increments. When the counter equals `ESPERA_MAX` → PARADO with `erro_mem` set.
    - `mem_pronta` = 1 in the same cycle the counter reaches the limit: ready wins, no fault.
    - The wait counter clears on entry to MEMORIA.
  - ESCRITA: `reg_escreve` = 1; `mem_reg` = 1 for LW, 0 for ALU. Next state is BUSCA.
  - PARADO: `halt` = 1 and all strobes 0. Only `reset` exits this state.
- `instr_concluidas` increments on every transition into BUSCA from EXECUTA, MEMORIA or ESCRITA, illegal opcodes included. It does not increment on entry to PARADO.
- All outputs not listed for a state are 0.

## Timing
- Reset values:
  - state = BUSCA, `estado` = 000.
  - `instr_concluidas` = 0, `erro_mem` = 0, wait counter = 0.
  - While `reset` is high, every strobe, `halt` and `ilegal` is forced to 0.
- The first fetch strobe occurs in the first cycle after `reset` deasserts.
- Latency in cycles, BUSCA to next BUSCA:
  - BEQ, JUMP, illegal: 3
  - ALU: 4
  - SW: 4 + w
  - LW: 5 + w
  - w = number of MEMORIA cycles with `mem_pronta` = 0.
- HALT: `halt` rises 2 cycles after BUSCA and stays high.
- `reset` asserted mid-instruction (including MEMORIA): the next state is BUSCA, any pending memory strobe drops immediately, and the partial instruction is not counted.
- Strobes are Moore outputs (state plus latched opcode), except the BEQ PC write.

## Structure
- Shared package holds:
  - state encodings BUSCA = 0, DECODIFICA = 1, EXECUTA = 2, MEMORIA = 3, ESCRITA = 4, PARADO = 5
  - opcode constants
  - `pc_origem` codes
- Sub-module `decodificador_classe`: combinational opcode → one-hot class (lw, sw, beq, alu, jump, halt, ilegal), instantiated once on the latched opcode.

## Test plan
- Reset, then `instrucao` = 8'b10011001 (ALU) → `ir_escreve` in cycle 1; `origem` = 1 and `op_alu` = 1 in cycle 3; `reg_escreve` = 1, `mem_reg` = 0 in cycle 4; `instr_concluidas` = 1.
- LW 8'b11001000 with `mem_pronta` high on the 2nd MEMORIA cycle → `le_mem` high for 2 cycles, then `reg_escreve` = 1 and `mem_reg` = 1; total 6 cycles.
- BEQ 8'b00101000 with `ula_zero` = 1, then a second run with `ula_zero` = 0 → first run: `pc_escreve` = 1, `pc_origem` = 01 in EXECUTA; second run: no PC write in EXECUTA.
- SW 8'b11010001 with `mem_pronta` held low, `ESPERA_MAX` = 4 → `escreve_mem` high for 4 cycles, then `halt` = 1 and `erro_mem` = 1, stable until reset.
- `instrucao` = 8'b01010000 → `ilegal` pulses for exactly one cycle in EXECUTA, no other strobe, and the core returns to BUSCA; then 8'b11111000 → `halt` = 1.
- `reset` asserted in MEMORIA → `le_mem` = 0 in the same cycle, `estado` = 000, `instr_concluidas` = 0; issue 256 JUMPs → `instr_concluidas` wraps to 0.
